crossbar_nxm: RTL and testbench
===============================

# crossbar_nxm

Parametrised N-master × M-slave request/acknowledge crossbar, the successor to the fixed 2×2 crossbar. Each slave port has a registered round-robin arbiter with a small state machine. It forwards the granted master's command, address and write data to the slave, then routes the slave's acknowledge and read data back to that master only. A per-slave response timeout returns an error acknowledge when a slave never answers, which the 2×2 block cannot do.

## Interface
- N_MASTERS, 2, number of master ports (≥2)
- N_SLAVES, 2, number of slave ports, power of two (≥2); SEL_W = clog2(N_SLAVES)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, slave response limit in cycles; 0 disables timeout
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- master_req  in  N_MASTERS  request, one bit per master
- master_cmd  in  N_MASTERS  0 = read, 1 = write
- master_addr  in  N_MASTERS*ADDR_W  master i at [i*ADDR_W +: ADDR_W]
- master_wdata  in  N_MASTERS*DATA_W  master i at [i*DATA_W +: DATA_W]
- master_rdata  out  N_MASTERS*DATA_W  read data, valid only with master_ack
- master_ack  out  N_MASTERS  one-cycle completion pulse
- master_err  out  N_MASTERS  qualifies master_ack: 1 = timeout
- slave_req  out  N_SLAVES  request to slave
- slave_cmd  out  N_SLAVES  forwarded cmd
- slave_addr  out  N_SLAVES*ADDR_W  forwarded address
- slave_wdata  out  N_SLAVES*DATA_W  forwarded write data
- slave_rdata  in  N_SLAVES*DATA_W  slave read data, valid with slave_ack
- slave_ack  in  N_SLAVES  slave completion

## Operation
- Decode: target slave = master_addr[ADDR_W-1 -: SEL_W]. Every address maps to a slave, so there is no decode error.
- Master rules: one outstanding transaction per master. Hold req, cmd, addr and wdata stable until ack. Keeping req high after ack issues a new transaction.
- Per-slave FSM states:
  - IDLE → BUSY: entered when any master requests this slave. Grant register g is loaded with the winner, and the timeout counter is cleared.
  - BUSY: slave_req = 1. slave_cmd, slave_addr and slave_wdata follow master g's live inputs. master_ack[g] = slave_ack and master_rdata[g] = slave_rdata, combinational, in the same cycle. On slave_ack → IDLE. Otherwise, when the counter reaches TIMEOUT-1 → TOUT; else the counter increments.
  - TOUT: slave_req = 0, master_ack[g] = 1, master_err[g] = 1, master_rdata[g] = 0. Unconditionally → IDLE.
- Round robin: per-slave pointer p. The winner is the first requesting master at index p, p+1, …, wrapping mod N_MASTERS. On grant, p ← g+1 mod N_MASTERS.
- Independent slaves arbitrate in parallel. Masters targeting different slaves are granted in the same cycle.
- A slave in IDLE ignores slave_ack. A late ack after timeout is dropped.
- Idle outputs are zero: slave_req/cmd/addr/wdata = 0, and master_ack/err/rdata = 0 for masters with no active grant. Output muxes are AND-OR over the grants, so zero-idle is required.
- TIMEOUT = 0: the TOUT state is unreachable and BUSY waits indefinitely.

## Timing
- Reset (rst_n = 0 at an edge): all FSMs go to IDLE, all pointers to 0, counters to 0. Every output is 0 from the following cycle, including mid-transaction. In-flight transactions are abandoned with no ack.
- Grant latency: master_req is sampled high in cycle 0, so slave_req is high in cycle 1.
- Zero-wait slave: slave_ack in cycle 1 gives master_ack in cycle 1. The slave is IDLE in cycle 2 and can grant again for cycle 3. Minimum spacing is 2 cycles per transaction per slave.
- Timeout: with no ack in BUSY cycles 1..TIMEOUT, TOUT occurs in cycle TIMEOUT+1 and the error ack is in that cycle.
- slave_ack in the same cycle the counter expires: the ack wins, with a normal completion and master_err = 0.
- Counter width is clog2(TIMEOUT+1). It never wraps.

## Test plan
- Reset, N=2, M=2: hold rst_n = 0 while master_req = 2'b11. All outputs stay 0. Release rst_n; slave_req rises one cycle later.
- Parallel grants: M0 addr 0x0000_0010 write and M1 addr 0x8000_0020 read, same cycle. Both slave_req are high next cycle. slave_1 returns rdata 0xDEADBEEF, so master_1 receives ack and 0xDEADBEEF, and M0 receives only its own ack.
- Contention: both masters hit slave 0 continuously with a zero-wait slave. Grants alternate M0, M1, M0, M1, one completion every 2 cycles, and no master_ack lands on the non-granted master.
- Wrap: N_MASTERS = 3, pointer at 2, requests from M0 and M1. M0 wins and the pointer becomes 1.
- Timeout, TIMEOUT = 4: slave 1 never acks. The error ack is in cycle 5 with master_err = 1 and rdata = 0. A slave_ack in cycle 6 is ignored.
- Mid-operation reset and expiry race: rst_n low during BUSY gives no ack, and the pointer returns to 0. Separately, slave_ack exactly on the expiry cycle gives ack = 1 and err = 0.

Source files
------------

// File: rtl/crossbar_nxm_if.sv
// Master-side and slave-side signal bundle of the N x M crossbar. The 'slave' view is the crossbar
// itself; the 'master' view is whatever drives it (masters and slave responders together).
interface crossbar_nxm_if #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
);
    logic [N_MASTERS-1:0]        master_req;
    logic [N_MASTERS-1:0]        master_cmd;
    logic [N_MASTERS*ADDR_W-1:0] master_addr;
    logic [N_MASTERS*DATA_W-1:0] master_wdata;
    logic [N_MASTERS*DATA_W-1:0] master_rdata;
    logic [N_MASTERS-1:0]        master_ack;
    logic [N_MASTERS-1:0]        master_err;
    logic [N_SLAVES-1:0]         slave_req;
    logic [N_SLAVES-1:0]         slave_cmd;
    logic [N_SLAVES*ADDR_W-1:0]  slave_addr;
    logic [N_SLAVES*DATA_W-1:0]  slave_wdata;
    logic [N_SLAVES*DATA_W-1:0]  slave_rdata;
    logic [N_SLAVES-1:0]         slave_ack;

    modport master (
        output master_req, master_cmd, master_addr, master_wdata, slave_rdata, slave_ack,
        input  master_rdata, master_ack, master_err, slave_req, slave_cmd, slave_addr, slave_wdata
    );

    modport slave (
        input  master_req, master_cmd, master_addr, master_wdata, slave_rdata, slave_ack,
        output master_rdata, master_ack, master_err, slave_req, slave_cmd, slave_addr, slave_wdata
    );
endinterface

// File: rtl/crossbar_nxm.sv
// N-master x M-slave req/ack crossbar, per-slave round-robin arbiter and response timeout.
// Grant latency 1 cycle, ack routed combinationally; masters hold req until ack (no other backpressure).
module crossbar_nxm #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    crossbar_nxm_if.slave bus
);
    localparam int SEL_W   = $clog2(N_SLAVES);
    localparam int MI_W    = $clog2(N_MASTERS);
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_TOUT = 2'd2
    } state_t;

    state_t               state_q [N_SLAVES];
    state_t               state_d [N_SLAVES];
    logic [MI_W-1:0]      grant_q [N_SLAVES];
    logic [MI_W-1:0]      ptr_q   [N_SLAVES];
    logic [CNT_W-1:0]     cnt_q   [N_SLAVES];

    logic [N_MASTERS-1:0] hit     [N_SLAVES];
    logic [N_SLAVES-1:0]  any_req;
    logic [N_SLAVES-1:0]  hi_vld;
    logic [MI_W-1:0]      hi_idx  [N_SLAVES];
    logic [MI_W-1:0]      lo_idx  [N_SLAVES];
    logic [MI_W-1:0]      win     [N_SLAVES];
    logic [MI_W-1:0]      ptr_nxt [N_SLAVES];
    logic [N_SLAVES-1:0]  expire;

    logic [N_SLAVES-1:0]         s_req;
    logic [N_SLAVES-1:0]         s_cmd;
    logic [N_SLAVES*ADDR_W-1:0]  s_addr;
    logic [N_SLAVES*DATA_W-1:0]  s_wdata;
    logic [N_MASTERS-1:0]        m_ack;
    logic [N_MASTERS-1:0]        m_err;
    logic [N_MASTERS*DATA_W-1:0] m_rdata;

    // Address decode: the top SEL_W address bits pick the slave.
    always_comb begin
        for (int s = 0; s < N_SLAVES; s++) begin
            hit[s] = '0;
            for (int m = 0; m < N_MASTERS; m++) begin
                hit[s][m] = bus.master_req[m] &&
                            (bus.master_addr[m*ADDR_W + ADDR_W - 1 -: SEL_W] == SEL_W'(s));
            end
        end
    end

    // Round robin without a modulo: the lowest requester at or above the pointer wins,
    // otherwise the lowest requester overall (the wrapped part of the scan).
    always_comb begin
        for (int s = 0; s < N_SLAVES; s++) begin
            any_req[s] = |hit[s];
            hi_vld[s]  = 1'b0;
            hi_idx[s]  = '0;
            lo_idx[s]  = '0;
            for (int m = N_MASTERS - 1; m >= 0; m--) begin
                if (hit[s][m]) begin
                    lo_idx[s] = MI_W'(m);
                    if (MI_W'(m) >= ptr_q[s]) begin
                        hi_vld[s] = 1'b1;
                        hi_idx[s] = MI_W'(m);
                    end
                end
            end
            win[s]     = hi_vld[s] ? hi_idx[s] : lo_idx[s];
            ptr_nxt[s] = (win[s] == MI_W'(N_MASTERS - 1)) ? '0 : win[s] + 1'b1;
            expire[s]  = (TIMEOUT != 0) && (cnt_q[s] == CNT_W'(TO_LAST));
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < N_SLAVES; s++) begin
            if (!rst_n) begin
                state_q[s] <= S_IDLE;
            end else begin
                state_q[s] <= state_d[s];
            end
        end
    end

    // Ack beats expiry when both land in the same cycle.
    always_comb begin
        for (int s = 0; s < N_SLAVES; s++) begin
            state_d[s] = state_q[s];
            case (state_q[s])
                S_IDLE: if (any_req[s]) state_d[s] = S_BUSY;
                S_BUSY: begin
                    if (bus.slave_ack[s]) begin
                        state_d[s] = S_IDLE;
                    end else if (expire[s]) begin
                        state_d[s] = S_TOUT;
                    end
                end
                S_TOUT:  state_d[s] = S_IDLE;
                default: state_d[s] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < N_SLAVES; s++) begin
            if (!rst_n) begin
                grant_q[s] <= '0;
                ptr_q[s]   <= '0;
                cnt_q[s]   <= '0;
            end else if (state_q[s] == S_IDLE && any_req[s]) begin
                grant_q[s] <= win[s];
                ptr_q[s]   <= ptr_nxt[s];
                cnt_q[s]   <= '0;
            end else if (TIMEOUT != 0 && state_q[s] == S_BUSY &&
                         !bus.slave_ack[s] && !expire[s]) begin
                cnt_q[s]   <= cnt_q[s] + 1'b1;
            end
        end
    end

    // AND-OR output muxing: every term is zero unless its slave holds a live grant.
    always_comb begin
        s_req   = '0;
        s_cmd   = '0;
        s_addr  = '0;
        s_wdata = '0;
        m_ack   = '0;
        m_err   = '0;
        m_rdata = '0;
        for (int s = 0; s < N_SLAVES; s++) begin
            for (int m = 0; m < N_MASTERS; m++) begin
                if (grant_q[s] == MI_W'(m)) begin
                    if (state_q[s] == S_BUSY) begin
                        s_req[s]                      = 1'b1;
                        s_cmd[s]                      = bus.master_cmd[m];
                        s_addr[s*ADDR_W +: ADDR_W]    = bus.master_addr[m*ADDR_W +: ADDR_W];
                        s_wdata[s*DATA_W +: DATA_W]   = bus.master_wdata[m*DATA_W +: DATA_W];
                        m_ack[m]                      = m_ack[m] | bus.slave_ack[s];
                        m_rdata[m*DATA_W +: DATA_W]   = m_rdata[m*DATA_W +: DATA_W] |
                                                        bus.slave_rdata[s*DATA_W +: DATA_W];
                    end else if (state_q[s] == S_TOUT) begin
                        m_ack[m] = 1'b1;
                        m_err[m] = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.slave_req    = s_req;
    assign bus.slave_cmd    = s_cmd;
    assign bus.slave_addr   = s_addr;
    assign bus.slave_wdata  = s_wdata;
    assign bus.master_ack   = m_ack;
    assign bus.master_err   = m_err;
    assign bus.master_rdata = m_rdata;
endmodule

// File: tb/tb_crossbar_nxm.sv
// Directed scenarios then random traffic, every cycle compared with a transaction-level model.
module tb_crossbar_nxm;
    localparam int NM = 3;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    crossbar_nxm_if #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    crossbar_nxm #(
        .N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: per slave, whether it is serving, serving for how many cycles, and whose turn is next.
    bit      m_busy [NS];
    bit      m_tout [NS];
    int      m_own  [NS];
    int      m_age  [NS];
    int      m_ptr  [NS];
    logic [NM-1:0] ack_seen;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int target(input int m);
        return int'(bus.master_addr[m*AW + AW - 1]);
    endfunction

    task automatic mset(input int m, input bit req, input bit cmd,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        bus.master_req[m]              = req;
        bus.master_cmd[m]              = cmd;
        bus.master_addr[m*AW +: AW]    = addr;
        bus.master_wdata[m*DW +: DW]   = wd;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Compare all outputs mid-cycle, then advance the model across the coming edge.
    task automatic settle();
        logic [NS-1:0]    e_sreq, e_scmd;
        logic [NS*AW-1:0] e_saddr;
        logic [NS*DW-1:0] e_swd;
        logic [NM-1:0]    e_ack, e_err;
        logic [NM*DW-1:0] e_rd;
        bit               done;
        @(negedge clk);
        e_sreq = '0; e_scmd = '0; e_saddr = '0; e_swd = '0;
        e_ack = '0; e_err = '0; e_rd = '0;
        for (int s = 0; s < NS; s++) begin
            int o = m_own[s];
            if (m_busy[s]) begin
                e_sreq[s]           = 1'b1;
                e_scmd[s]           = bus.master_cmd[o];
                e_saddr[s*AW +: AW] = bus.master_addr[o*AW +: AW];
                e_swd[s*DW +: DW]   = bus.master_wdata[o*DW +: DW];
                e_ack[o]            = bus.slave_ack[s];
                e_rd[o*DW +: DW]    = bus.slave_rdata[s*DW +: DW];
            end else if (m_tout[s]) begin
                e_ack[o] = 1'b1;
                e_err[o] = 1'b1;
            end
        end
        chk("slave_req",    bus.slave_req,    e_sreq);
        chk("slave_cmd",    bus.slave_cmd,    e_scmd);
        chk("slave_addr",   bus.slave_addr,   e_saddr);
        chk("slave_wdata",  bus.slave_wdata,  e_swd);
        chk("master_ack",   bus.master_ack,   e_ack);
        chk("master_err",   bus.master_err,   e_err);
        chk("master_rdata", bus.master_rdata, e_rd);
        ack_seen = e_ack;
        for (int s = 0; s < NS; s++) begin
            if (!rst_n) begin
                m_busy[s] = 1'b0; m_tout[s] = 1'b0; m_ptr[s] = 0;
            end else if (m_tout[s]) begin
                m_tout[s] = 1'b0;
            end else if (m_busy[s]) begin
                if (bus.slave_ack[s]) begin
                    m_busy[s] = 1'b0;
                end else if (TO != 0 && m_age[s] == TO) begin
                    m_busy[s] = 1'b0; m_tout[s] = 1'b1;
                end else begin
                    m_age[s]++;
                end
            end else begin
                done = 1'b0;
                for (int k = 0; k < NM; k++) begin
                    int m = (m_ptr[s] + k) % NM;
                    if (!done && bus.master_req[m] && target(m) == s) begin
                        done = 1'b1; m_busy[s] = 1'b1; m_own[s] = m; m_age[s] = 1;
                        m_ptr[s] = (m + 1) % NM;
                    end
                end
            end
        end
    endtask

    task automatic new_txn(input int m);
        mset(m, 1'b1, 1'($urandom), $urandom, $urandom);
    endtask

    initial begin
        for (int s = 0; s < NS; s++) begin
            m_busy[s] = 0; m_tout[s] = 0; m_own[s] = 0; m_age[s] = 0; m_ptr[s] = 0;
        end
        ack_seen = '0;
        rst_n = 1'b0;
        bus.master_req = '0; bus.master_cmd = '0; bus.master_addr = '0; bus.master_wdata = '0;
        bus.slave_ack = '0; bus.slave_rdata = '0;
        adv(); adv();

        // Reset held while two masters request: everything stays quiet.
        mset(0, 1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_0001);
        mset(1, 1'b1, 1'b0, 32'h8000_0020, 32'h0);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("rst_sreq", bus.slave_req, 2'b00);
            chk("rst_mack", bus.master_ack, 3'b000);
            adv();
        end
        rst_n = 1'b1;
        settle();
        chk("rel_sreq", bus.slave_req, 2'b00);
        adv();

        // Parallel grants to both slaves.
        bus.slave_ack = 2'b11;
        bus.slave_rdata = {32'hDEAD_BEEF, 32'h0BAD_F00D};
        settle();
        chk("par_sreq",  bus.slave_req, 2'b11);
        chk("par_cmd",   bus.slave_cmd, 2'b01);
        chk("par_addr0", bus.slave_addr[31:0], 32'h0000_0010);
        chk("par_wd0",   bus.slave_wdata[31:0], 32'hA5A5_0001);
        chk("par_addr1", bus.slave_addr[63:32], 32'h8000_0020);
        chk("par_ack",   bus.master_ack, 3'b011);
        chk("par_rd1",   bus.master_rdata[63:32], 32'hDEAD_BEEF);
        chk("par_err",   bus.master_err, 3'b000);
        adv();
        bus.master_req = '0; bus.slave_ack = '0;
        settle();
        chk("par_idle", bus.slave_req, 2'b00);
        adv();

        // Contention on slave 0 with a zero-wait responder; slave 0 pointer is at 1.
        mset(0, 1'b1, 1'b1, 32'h0000_0100, 32'h1111);
        mset(1, 1'b1, 1'b1, 32'h0000_0200, 32'h2222);
        for (int k = 0; k < 8; k++) begin
            bus.slave_ack[0] = bus.slave_req[0];
            settle();
            chk("cont_ack", bus.master_ack,
                (k % 2 == 0) ? 3'b000 : ((k == 1 || k == 5) ? 3'b010 : 3'b001));
            adv();
        end
        bus.master_req = '0; bus.slave_ack = '0;

        // Wrap: move the pointer to 2, then M0 and M1 race; M0 wins, then M1.
        mset(1, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        settle(); adv();
        bus.slave_ack[0] = 1'b1;
        settle();
        chk("wrap_pre", bus.master_ack, 3'b010);
        adv();
        bus.slave_ack[0] = 1'b0;
        mset(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
        mset(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        settle(); adv();
        bus.slave_ack[0] = 1'b1;
        settle();
        chk("wrap_addr", bus.slave_addr[31:0], 32'h0000_0400);
        chk("wrap_ack",  bus.master_ack, 3'b001);
        adv();
        bus.slave_ack[0] = 1'b0;
        settle(); adv();
        bus.slave_ack[0] = 1'b1;
        settle();
        chk("wrap_ptr1", bus.slave_addr[31:0], 32'h0000_0500);
        chk("wrap_ack1", bus.master_ack, 3'b010);
        adv();
        bus.master_req = '0; bus.slave_ack = '0;
        settle(); adv();

        // Timeout on slave 1: error ack in cycle 5, late ack in cycle 6 dropped.
        bus.slave_rdata[63:32] = 32'hCAFE_0001;
        mset(2, 1'b1, 1'b0, 32'h8000_0040, 32'h0);
        settle(); adv();
        for (int c = 1; c <= TO; c++) begin
            settle();
            chk("to_sreq", bus.slave_req[1], 1'b1);
            chk("to_wait", bus.master_ack, 3'b000);
            adv();
        end
        settle();
        chk("to_ack",   bus.master_ack, 3'b100);
        chk("to_err",   bus.master_err, 3'b100);
        chk("to_rdata", bus.master_rdata[95:64], 32'h0);
        chk("to_sreq0", bus.slave_req, 2'b00);
        adv();
        bus.master_req[2] = 1'b0;
        bus.slave_ack[1] = 1'b1;
        settle();
        chk("late_ack", bus.master_ack, 3'b000);
        chk("late_err", bus.master_err, 3'b000);
        adv();
        bus.slave_ack = '0;

        // Ack exactly on the expiry cycle wins.
        bus.slave_rdata[63:32] = 32'h1234_5678;
        mset(1, 1'b1, 1'b0, 32'h8000_0080, 32'h0);
        settle(); adv();
        for (int c = 1; c < TO; c++) begin
            settle();
            chk("race_wait", bus.master_ack, 3'b000);
            adv();
        end
        bus.slave_ack[1] = 1'b1;
        settle();
        chk("race_ack", bus.master_ack, 3'b010);
        chk("race_err", bus.master_err, 3'b000);
        chk("race_rd",  bus.master_rdata[63:32], 32'h1234_5678);
        adv();
        bus.master_req = '0; bus.slave_ack = '0;
        settle();
        chk("race_idle", bus.master_ack, 3'b000);
        adv();

        // Mid-transaction reset: no ack, pointer returns to 0 (M0 beats M1 afterwards).
        mset(0, 1'b1, 1'b1, 32'h0000_0600, 32'h77);
        settle(); adv();
        settle();
        chk("mr_busy", bus.slave_req, 2'b01);
        adv();
        rst_n = 1'b0;
        settle();
        chk("mr_nack", bus.master_ack, 3'b000);
        adv();
        settle();
        chk("mr_sreq", bus.slave_req, 2'b00);
        chk("mr_mack", bus.master_ack, 3'b000);
        adv();
        rst_n = 1'b1;
        mset(1, 1'b1, 1'b0, 32'h0000_0700, 32'h0);
        settle(); adv();
        bus.slave_ack[0] = 1'b1;
        settle();
        chk("mr_ptr0", bus.slave_addr[31:0], 32'h0000_0600);
        chk("mr_ack",  bus.master_ack, 3'b001);
        adv();
        bus.master_req = '0; bus.slave_ack = '0;
        settle(); adv();

        // Random traffic under the master rules, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < NM; m++) begin
                if (bus.master_req[m]) begin
                    if (ack_seen[m]) begin
                        if ($urandom_range(1, 0) == 1) new_txn(m);
                        else bus.master_req[m] = 1'b0;
                    end
                end else if ($urandom_range(9, 0) < 3) begin
                    new_txn(m);
                end
            end
            rst_n = ($urandom_range(199, 0) != 0);
            for (int s = 0; s < NS; s++) begin
                int pct = m_busy[s] ? ((s == 0) ? 60 : 20) : 10;
                bus.slave_rdata[s*DW +: DW] = $urandom;
                bus.slave_ack[s] = ($urandom_range(99, 0) < pct);
            end
            settle();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
